// File: rtl/mem_wb_sram_stage.sv
// MEM stage + MEM/WB register: 32-bit loads/stores as two half-word SRAM accesses. ALU ops 1 cycle;
// memory ops occupy 2*SRAM_WAIT+2 cycles with freeze high for the first 2*SRAM_WAIT+1; inputs held while frozen.
module mem_wb_sram_stage #(
  parameter int          SRAM_WAIT = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_en_in,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        st_val,
  input  logic [3:0]         dest_in,
  output logic               freeze,
  output logic               wb_en,
  output logic [3:0]         dest_wb,
  output logic [31:0]        result_wb,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  input  logic [15:0]        sram_dq_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int            CW       = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lo_q, lo_d;
  logic [15:0]   hi_q, hi_d;
  logic          wb_en_q, wb_en_d;
  logic [3:0]    dest_wb_q, dest_wb_d;
  logic [31:0]   result_wb_q, result_wb_d;

  logic               req;
  logic               is_load;
  logic               is_store;
  logic               phase_last;
  logic               freeze_int;
  logic [SRAM_AW:0]   off;
  logic [SRAM_AW-2:0] word;
  logic               off_byte_unused;

  assign req        = mem_r_en | mem_w_en;
  assign is_load    = mem_r_en;
  // A load wins when both enables are raised; the store half is dropped.
  assign is_store   = mem_w_en & ~mem_r_en;
  assign phase_last = (cnt_q == CNT_LAST);

  // Only the low SRAM_AW+1 bits of the offset matter, so subtract at that width.
  assign off             = alu_result[SRAM_AW:0] - BASE_ADDR[SRAM_AW:0];
  assign word            = off[SRAM_AW:2];
  assign off_byte_unused = ^off[1:0];

  assign freeze_int = ((state_q == S_IDLE) & req) | (state_q == S_LO) | (state_q == S_HI);
  assign freeze     = reset & freeze_int;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LO;
          cnt_d   = '0;
        end
      end
      S_LO: begin
        if (phase_last) begin
          state_d = S_HI;
          cnt_d   = '0;
          if (is_load) lo_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        if (phase_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (is_load) hi_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state_q == S_LO) begin
      sram_addr = {word, 1'b0};
      if (is_store) begin
        sram_dq_out = st_val[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
    end else if (state_q == S_HI) begin
      sram_addr = {word, 1'b1};
      if (is_store) begin
        sram_dq_out = st_val[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
    end
  end

  // While frozen a bubble enters the MEM/WB register so the register file never sees an early or repeated write.
  always_comb begin
    wb_en_d     = 1'b0;
    dest_wb_d   = dest_wb_q;
    result_wb_d = result_wb_q;
    if (!freeze_int) begin
      wb_en_d     = wb_en_in & ~is_store;
      dest_wb_d   = dest_in;
      result_wb_d = mem_r_en ? {hi_q, lo_q} : alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      wb_en_q     <= 1'b0;
      dest_wb_q   <= '0;
      result_wb_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      wb_en_q     <= wb_en_d;
      dest_wb_q   <= dest_wb_d;
      result_wb_q <= result_wb_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign dest_wb   = dest_wb_q;
  assign result_wb = result_wb_q;

endmodule

// File: tb/tb_mem_wb_sram_stage.sv
// Bench for mem_wb_sram_stage: directed cases plus random op streams against a word-level memory model.
module tb_mem_wb_sram_stage;
  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          AW   = 18;

  logic          clk;
  logic          reset;
  logic          wb_en_in, mem_r_en, mem_w_en;
  logic [31:0]   alu_result, st_val;
  logic [3:0]    dest_in;
  logic          freeze, wb_en;
  logic [3:0]    dest_wb;
  logic [31:0]   result_wb;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  mem_wb_sram_stage #(.SRAM_WAIT(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
    .clk(clk), .reset(reset), .wb_en_in(wb_en_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .st_val(st_val), .dest_in(dest_in), .freeze(freeze), .wb_en(wb_en),
    .dest_wb(dest_wb), .result_wb(result_wb), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_dq_in(sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SRAM: asynchronous read, write strobed mid-cycle.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(negedge clk) if (reset && !sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  // Reference model: 32-bit words indexed by (addr - BASE) / 4.
  logic [31:0] ref_words [0:15];

  int total = 0;
  int bad = 0;
  int n_wb_seen = 0;
  int n_wb_exp = 0;
  logic        p_wb;
  logic [3:0]  p_dest;
  logic [31:0] p_res;

  always @(negedge clk) if (wb_en) n_wb_seen <= n_wb_seen + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic preset(input int i, input logic [31:0] v);
    ref_words[i]      = v;
    sram_mem[2*i]     = v[15:0];
    sram_mem[2*i + 1] = v[31:16];
  endtask

  task automatic check_pending();
    chk("wb_en", {31'b0, wb_en}, {31'b0, p_wb});
    chk("dest_wb", {28'b0, dest_wb}, {28'b0, p_dest});
    chk("result_wb", result_wb, p_res);
    if (p_wb) n_wb_exp++;
  endtask

  task automatic do_op(input logic wb, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] s, input logic [3:0] d);
    int          cyc;
    logic        st;
    logic        hi;
    logic [31:0] off;
    logic [16:0] word;
    logic [15:0] exp_dq;
    @(negedge clk);
    check_pending();
    wb_en_in = wb; mem_r_en = r; mem_w_en = w; alu_result = a; st_val = s; dest_in = d;
    st   = w & ~r;
    off  = a - BASE;
    word = off[18:2];
    #1;
    cyc = 0;
    while (freeze && cyc < 40) begin
      if (cyc == 0) begin
        chk("idle_drive", {12'b0, sram_we_n, sram_dq_oe, sram_addr}, {12'b0, 1'b1, 1'b0, 18'b0});
      end else begin
        hi     = (cyc > W);
        exp_dq = st ? (hi ? s[31:16] : s[15:0]) : 16'h0;
        chk("sram_addr", {14'b0, sram_addr}, {14'b0, word, hi});
        chk("sram_we_n", {31'b0, sram_we_n}, {31'b0, ~st});
        chk("sram_dq_oe", {31'b0, sram_dq_oe}, {31'b0, st});
        chk("sram_dq_out", {16'b0, sram_dq_out}, {16'b0, exp_dq});
        chk("wb_bubble", {31'b0, wb_en}, 32'd0);
      end
      @(negedge clk); #1;
      cyc++;
    end
    chk("freeze_len", cyc, (r | w) ? 2*W + 1 : 0);
    if (r | w) begin
      chk("done_drive", {12'b0, sram_we_n, sram_dq_oe, sram_addr}, {12'b0, 1'b1, 1'b0, 18'b0});
      chk("done_bubble", {31'b0, wb_en}, 32'd0);
    end
    p_wb   = wb & ~st;
    p_dest = d;
    p_res  = r ? ref_words[word[3:0]] : a;
    if (st) ref_words[word[3:0]] = s;
  endtask

  task automatic reset_mid_load(input logic [31:0] a, input logic [3:0] d);
    @(negedge clk);
    check_pending();
    wb_en_in = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0; alu_result = a; st_val = 32'h0; dest_in = d;
    // Three edges bring the FSM to the first HI cycle.
    repeat (W + 1) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst_freeze", {31'b0, freeze}, 32'd0);
    wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = 32'h0; dest_in = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_freeze", {31'b0, freeze}, 32'd0);
      chk("post_wb_en", {31'b0, wb_en}, 32'd0);
      chk("post_result", result_wb, 32'd0);
      chk("post_dest", {28'b0, dest_wb}, 32'd0);
      chk("post_addr", {14'b0, sram_addr}, 32'd0);
    end
    p_wb = 1'b0; p_dest = 4'h0; p_res = 32'h0;
  endtask

  initial begin
    logic [31:0] ra;
    int          k;
    reset = 1'b0;
    wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    alu_result = 32'h0; st_val = 32'h0; dest_in = 4'h0;
    for (int i = 0; i < 16; i++) preset(i, $urandom);
    preset(2, 32'h2222_1111);
    #2;
    chk("reset_state", {wb_en, dest_wb, sram_dq_oe, sram_we_n, freeze, 9'b0, sram_addr[15:0]},
        {1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 9'b0, 16'h0});
    chk("reset_result", result_wb, 32'h0);
    chk("reset_dq_out", {16'b0, sram_dq_out}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    p_wb = 1'b0; p_dest = 4'h0; p_res = 32'h0;

    do_op(1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h0, 4'd3);
    do_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7);
    do_op(1'b1, 1'b0, 1'b0, 32'd5, 32'h0, 4'd2);
    do_op(1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd1);
    do_op(1'b1, 1'b1, 1'b0, 32'd1033, 32'h0, 4'd4);
    do_op(1'b1, 1'b1, 1'b1, 32'd1044, 32'hFFFF_0000, 4'd9);
    reset_mid_load(32'd1040, 4'd6);

    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 4);
      ra = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      case (k)
        0, 1: do_op(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
        2:    do_op(1'($urandom), 1'b1, 1'b0, ra, $urandom, 4'($urandom));
        3:    do_op(1'($urandom), 1'b0, 1'b1, ra, $urandom, 4'($urandom));
        default: do_op(1'($urandom), 1'b1, 1'b1, ra, $urandom, 4'($urandom));
      endcase
    end
    do_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("wb_pulses", n_wb_seen, n_wb_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mem_wb_sram_stage.md
Name: mem_wb_sram_stage

Overview:
- Memory stage of the ARM pipeline plus the MEM/WB pipeline register.
- Takes EXE-stage results, performs 32-bit loads/stores on an external 16-bit SRAM as two half-word accesses, and freezes the upstream pipeline while busy.
- Drives the write-back triple (wb_en, dest_wb, result_wb) directly into the register file's write port. The register file writes on negedge, so the triple must be stable from each posedge.

Parameters:
- SRAM_WAIT, 2, cycles each SRAM half-access is held (min 1).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wb_en_in  in  1  EXE-stage write-back enable.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- alu_result  in  32  byte address for memory ops; result for non-memory ops.
- st_val  in  32  store data.
- dest_in  in  4  destination register index.
- freeze  out  1  stall upstream stages; inputs must be held stable while high.
- wb_en  out  1  register-file write enable.
- dest_wb  out  4  register-file write index.
- result_wb  out  32  register-file write data.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_oe  out  1  SRAM data bus drive enable.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_dq_in  in  16  SRAM read data.

Behaviour:
- Reset (low, asynchronous, immediate):
  - FSM goes to IDLE; wait counter cleared.
  - wb_en=0, dest_wb=0, result_wb=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - freeze is forced to 0 while reset is low.
- Address mapping:
  - off = alu_result - BASE_ADDR, modulo 2^32, no range check.
  - word = off[SRAM_AW:2]; bits [1:0] ignored.
  - Low half at sram_addr={word,0}; high half at {word,1}.
- Request:
  - req = mem_r_en | mem_w_en.
  - If both enables are high, the op is treated as a load; the store is ignored.
- FSM states and transitions:
  - IDLE: if req, go to LO with counter=0.
  - LO: held SRAM_WAIT cycles, then go to HI with counter=0.
  - HI: held SRAM_WAIT cycles, then go to DONE.
  - DONE: one cycle, then IDLE.
  - DONE does not check req; the next op is evaluated only in IDLE.
- freeze = (IDLE & req) | LO | HI. This is combinational from state and inputs.
  - A memory op occupies the stage for 2*SRAM_WAIT+2 cycles, with freeze high for the first 2*SRAM_WAIT+1 of them.
- SRAM drive in LO and HI:
  - sram_addr is the low or high half address respectively.
  - Load: sram_we_n=1, sram_dq_oe=0. sram_dq_in is captured on the last cycle of LO into lo_q, and on the last cycle of HI into hi_q.
  - Store: sram_we_n=0, sram_dq_oe=1 for every cycle of the phase; sram_dq_out = st_val[15:0] in LO, st_val[31:16] in HI.
- SRAM drive in IDLE and DONE: sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- MEM/WB register, updated at posedge:
  - When freeze=0: wb_en <= wb_en_in & ~(mem_w_en & ~mem_r_en); dest_wb <= dest_in; result_wb <= mem_r_en ? {hi_q,lo_q} : alu_result.
  - When freeze=1: a bubble is loaded (wb_en <= 0; dest_wb and result_wb hold), so no repeated or early register write occurs.
- Latency:
  - Non-memory op: one cycle (inputs at edge k appear at outputs after edge k+1).
  - Load result: visible after the edge that ends DONE.
- Reset mid-operation aborts the SRAM access with no write-back; a partial store may leave the low half written.

Test Plan:
- Non-memory op, SRAM_WAIT=2: wb_en_in=1, dest_in=3, alu_result=32'h0000_00AB, no mem enable -> after the next posedge wb_en=1, dest_wb=3, result_wb=32'h0000_00AB; freeze never high.
- Store, SRAM_WAIT=2: alu_result=1032, st_val=32'hDEAD_BEEF -> freeze high 5 cycles.
  - sram_addr=4, sram_dq_out=16'hBEEF, sram_we_n=0 for 2 cycles.
  - Then sram_addr=5, sram_dq_out=16'hDEAD for 2 cycles.
  - wb_en stays 0 throughout.
- Load, SRAM_WAIT=2: SRAM model returns 16'h1111 at address 4 and 16'h2222 at address 5; alu_result=1032, dest_in=7 -> freeze high exactly 5 cycles, then result_wb=32'h2222_1111, wb_en=1, dest_wb=7 for one cycle.
- Load followed by an ALU op (dest 2, value 5) held upstream during freeze -> load write-back, then dest_wb=2, result_wb=5 on the following cycle; no duplicated wb_en pulse.
- Reset pulled low during the HI phase of a load -> immediately sram_we_n=1, sram_dq_oe=0, wb_en=0, freeze=0; after release with no request the FSM stays IDLE and outputs stay at reset values.
- mem_r_en=1 and mem_w_en=1 together -> load behaviour: sram_we_n never 0, and the write-back carries SRAM data.
